// File: rtl/avmm_master_pkg.sv
// Shared types for the Avalon-MM command master: FSM states and the latched command record.
// cmd_t is sized for the widest supported bus; the master zero-extends into it.
package avmm_master_pkg;

  localparam int unsigned MaxDataWidth = 256;
  localparam int unsigned MaxAddrWidth = 64;
  localparam int unsigned MaxBeWidth   = MaxDataWidth / 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitRd,
    StResp
  } state_t;

  typedef struct packed {
    logic                    write;
    logic [MaxAddrWidth-1:0] address;
    logic [MaxDataWidth-1:0] writedata;
    logic [MaxBeWidth-1:0]   byteenable;
  } cmd_t;

  function automatic cmd_t pack_cmd(input logic                    write,
                                    input logic [MaxAddrWidth-1:0] address,
                                    input logic [MaxDataWidth-1:0] writedata,
                                    input logic [MaxBeWidth-1:0]   byteenable);
    cmd_t c;
    c.write      = write;
    c.address    = address;
    c.writedata  = writedata;
    c.byteenable = byteenable;
    return c;
  endfunction

endpackage

// File: rtl/avmm_cmd_master.sv
// Single-outstanding Avalon-MM master: accepts one command, issues it to the slave, waits out
// waitrequest stalls (with optional timeout) and a fixed read latency, then returns one response.
module avmm_cmd_master
  import avmm_master_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = 32,
  parameter int unsigned ADDRESSWIDTH = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESSWIDTH-1:0] cmd_address,
  input  logic [DATAWIDTH-1:0]    cmd_writedata,
  input  logic [DATAWIDTH/8-1:0]  cmd_byteenable,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic                    rsp_error,
  output logic [DATAWIDTH-1:0]    rsp_readdata,

  output logic [ADDRESSWIDTH-1:0] avm_address,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [DATAWIDTH-1:0]    avm_writedata,
  output logic [DATAWIDTH/8-1:0]  avm_byteenable,
  input  logic [DATAWIDTH-1:0]    avm_readdata,
  input  logic                    avm_waitrequest
);

  localparam int unsigned StallW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t                 state_q;
  cmd_t                   cmd_q;
  logic                   cmd_ready_q;
  logic                   avm_read_q;
  logic                   avm_write_q;
  logic [3:0]             lat_q;
  logic [StallW-1:0]      stall_q;
  logic                   rsp_valid_q;
  logic                   rsp_write_q;
  logic                   rsp_error_q;
  logic [DATAWIDTH-1:0]   rsp_readdata_q;
  logic                   stall_last;

  // True on the stall cycle that brings the counter up to TIMEOUT.
  assign stall_last = (TIMEOUT != 0) && ((32'(stall_q) + 32'd1) == TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cmd_q          <= '0;
      cmd_ready_q    <= 1'b0;
      avm_read_q     <= 1'b0;
      avm_write_q    <= 1'b0;
      lat_q          <= '0;
      stall_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_error_q    <= 1'b0;
      rsp_readdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_q       <= pack_cmd(cmd_write, MaxAddrWidth'(cmd_address),
                                    MaxDataWidth'(cmd_writedata), MaxBeWidth'(cmd_byteenable));
            avm_read_q  <= !cmd_write;
            avm_write_q <= cmd_write;
            stall_q     <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (!avm_waitrequest) begin
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            if (cmd_q.write) begin
              rsp_valid_q    <= 1'b1;
              rsp_write_q    <= 1'b1;
              rsp_error_q    <= 1'b0;
              rsp_readdata_q <= '0;
              state_q        <= StResp;
            end else begin
              lat_q   <= 4'(READ_LATENCY - 1);
              state_q <= StWaitRd;
            end
          end else begin
            if (stall_q != '1) stall_q <= stall_q + StallW'(1);
            if (stall_last) begin
              avm_read_q     <= 1'b0;
              avm_write_q    <= 1'b0;
              rsp_valid_q    <= 1'b1;
              rsp_write_q    <= cmd_q.write;
              rsp_error_q    <= 1'b1;
              rsp_readdata_q <= '0;
              state_q        <= StResp;
            end
          end
        end
        StWaitRd: begin
          if (lat_q == '0) begin
            rsp_valid_q    <= 1'b1;
            rsp_write_q    <= 1'b0;
            rsp_error_q    <= 1'b0;
            rsp_readdata_q <= avm_readdata;
            state_q        <= StResp;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q    <= 1'b0;
            rsp_write_q    <= 1'b0;
            rsp_error_q    <= 1'b0;
            rsp_readdata_q <= '0;
            cmd_ready_q    <= 1'b1;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_error      = rsp_error_q;
  assign rsp_readdata   = rsp_readdata_q;
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_address    = cmd_q.address[ADDRESSWIDTH-1:0];
  assign avm_writedata  = cmd_q.writedata[DATAWIDTH-1:0];
  assign avm_byteenable = cmd_q.byteenable[DATAWIDTH/8-1:0];

  // Upper bits of the wide command record are padding for narrower buses.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_q;

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Randomized bench for avmm_cmd_master against a register-memory slave and a transaction-level
// model of the expected responses.
module tb_avmm_cmd_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RL = 1;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_address;
  logic [DW-1:0]   cmd_writedata;
  logic [DW/8-1:0] cmd_byteenable;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_write;
  logic            rsp_error;
  logic [DW-1:0]   rsp_readdata;
  logic [AW-1:0]   avm_address;
  logic            avm_read;
  logic            avm_write;
  logic [DW-1:0]   avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic [DW-1:0]   avm_readdata = '0;
  logic            avm_waitrequest;

  avmm_cmd_master #(
    .DATAWIDTH    (DW),
    .ADDRESSWIDTH (AW),
    .READ_LATENCY (RL),
    .TIMEOUT      (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_address     (cmd_address),
    .cmd_writedata   (cmd_writedata),
    .cmd_byteenable  (cmd_byteenable),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_write       (rsp_write),
    .rsp_error       (rsp_error),
    .rsp_readdata    (rsp_readdata),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Register-memory slave: stalls the first stall_target cycles of each request, latency 1.
  int unsigned stall_target = 0;
  int unsigned stall_cnt = 0;
  logic [31:0] slv_mem [16] = '{default: '0};

  assign avm_waitrequest = (avm_read || avm_write) && (stall_cnt < stall_target);

  always @(posedge clk) begin
    if (!(avm_read || avm_write)) begin
      stall_cnt <= 0;
    end else if (avm_waitrequest) begin
      stall_cnt <= stall_cnt + 1;
    end else if (avm_write) begin
      for (int b = 0; b < 4; b++)
        if (avm_byteenable[b]) slv_mem[avm_address[3:0]][8*b +: 8] <= avm_writedata[8*b +: 8];
    end else begin
      avm_readdata <= slv_mem[avm_address[3:0]];
    end
  end

  // Bus monitor: request length, first-cycle fields and their stability.
  int unsigned mon_cycles;
  int unsigned mon_start;
  logic [AW-1:0]   mon_addr;
  logic [DW-1:0]   mon_data;
  logic [DW/8-1:0] mon_be;
  logic            mon_unstable;
  logic            mon_both;

  always @(negedge clk) begin
    if (avm_read || avm_write) begin
      if (mon_cycles == 0) begin
        mon_start = cyc;
        mon_addr  = avm_address;
        mon_data  = avm_writedata;
        mon_be    = avm_byteenable;
      end else if (avm_address != mon_addr || avm_writedata != mon_data ||
                   avm_byteenable != mon_be) begin
        mon_unstable = 1'b1;
      end
      if (avm_read && avm_write) mon_both = 1'b1;
      mon_cycles++;
    end
  end

  // Transaction-level reference memory.
  logic [31:0] ref_mem [16];

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input int unsigned stalls,
                        input int unsigned hold);
    logic [31:0] exp_data;
    logic        exp_err;
    int unsigned exp_lat;
    int unsigned exp_cycles;
    int unsigned n;
    int unsigned rsp_cyc;
    exp_err  = (stalls >= TO);
    exp_data = '0;
    if (!exp_err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[addr % 16][8*b +: 8] = data[8*b +: 8];
      end else begin
        exp_data = ref_mem[addr % 16];
      end
    end
    exp_lat    = exp_err ? TO : (wr ? stalls + 1 : stalls + 1 + RL);
    exp_cycles = exp_err ? TO : stalls + 1;

    stall_target   = stalls;
    mon_cycles     = 0;
    mon_unstable   = 1'b0;
    mon_both       = 1'b0;
    cmd_write      = wr;
    cmd_address    = addr;
    cmd_writedata  = data;
    cmd_byteenable = be;
    cmd_valid      = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_ready_timeout", 64'(n < 20), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;

    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("rsp_valid_timeout", 64'(n < 100), 64'd1);
    rsp_cyc = cyc;
    check_eq("rsp_write", 64'(rsp_write), 64'(wr));
    check_eq("rsp_error", 64'(rsp_error), 64'(exp_err));
    check_eq("rsp_readdata", 64'(rsp_readdata), 64'(exp_data));
    check_eq("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    check_eq("avm_req_cycles", 64'(mon_cycles), 64'(exp_cycles));
    check_eq("avm_fields_stable", 64'(mon_unstable), 64'd0);
    check_eq("avm_rd_wr_both", 64'(mon_both), 64'd0);
    check_eq("avm_address", 64'(mon_addr), 64'(addr));
    check_eq("avm_writedata", 64'(mon_data), 64'(data));
    check_eq("avm_byteenable", 64'(mon_be), 64'(be));
    check_eq("rsp_latency", 64'(rsp_cyc - mon_start), 64'(exp_lat));

    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      check_eq("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check_eq("hold_rsp_readdata", 64'(rsp_readdata), 64'(exp_data));
      check_eq("hold_rsp_error", 64'(rsp_error), 64'(exp_err));
      check_eq("hold_rsp_write", 64'(rsp_write), 64'(wr));
      check_eq("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("post_hs_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    rst            = 1'b1;
    cmd_valid      = 1'b0;
    cmd_write      = 1'b0;
    cmd_address    = '0;
    cmd_writedata  = '0;
    cmd_byteenable = '0;
    rsp_ready      = 1'b0;
    mon_cycles     = 0;
    mon_unstable   = 1'b0;
    mon_both       = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_fields", 64'({rsp_write, rsp_error, rsp_readdata}), 64'd0);
    check_eq("rst_avm_ctrl", 64'({avm_read, avm_write}), 64'd0);
    check_eq("rst_avm_address", 64'(avm_address), 64'd0);
    check_eq("rst_avm_data_be", 64'({avm_writedata, avm_byteenable}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Basic write, then read back.
    do_txn(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 0, 0);
    do_txn(1'b0, 32'd5, 32'h0, 4'hF, 0, 0);
    // Three stall cycles on a write.
    do_txn(1'b1, 32'd9, 32'h1234_5678, 4'hF, 3, 0);
    // Stuck waitrequest on a read, then normal traffic.
    do_txn(1'b0, 32'd5, 32'h0, 4'hF, 1000, 0);
    do_txn(1'b0, 32'd9, 32'h0, 4'hF, 0, 0);
    // Response back-pressure.
    do_txn(1'b0, 32'd5, 32'h0, 4'hF, 0, 5);

    // Reset while the read sits in its latency wait.
    stall_target   = 0;
    cmd_write      = 1'b0;
    cmd_address    = 32'd5;
    cmd_valid      = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_avm_ctrl", 64'({avm_read, avm_write}), 64'd0);
    check_eq("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_txn(1'b0, 32'd5, 32'h0, 4'hF, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      int unsigned st;
      wr   = 1'($urandom_range(0, 1));
      addr = $urandom();
      data = $urandom();
      be   = 4'($urandom_range(0, 15));
      st   = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5);
      do_txn(wr, addr, data, be, st, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/avmm_cmd_master.md
AVMM_CMD_MASTER -- requirements
Module: avmm_cmd_master

Interface
REQ-001 Parameter DATAWIDTH, default 32, data bus width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDRESSWIDTH, default 32, Avalon word address width.
REQ-003 Parameter READ_LATENCY, default 1, fixed slave read latency in cycles; legal range 1..15.
REQ-004 Parameter TIMEOUT, default 255, maximum waitrequest stall cycles before abort; 0 disables the timeout.
REQ-005 The module has one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all logic on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 cmd_valid  input  1  command present.
REQ-009 cmd_ready  output  1  command accepted on the edge where cmd_valid and cmd_ready are both high.
REQ-010 cmd_write  input  1  1 = write, 0 = read.
REQ-011 cmd_address  input  ADDRESSWIDTH  target word address.
REQ-012 cmd_writedata  input  DATAWIDTH  write data.
REQ-013 cmd_byteenable  input  DATAWIDTH/8  byte lanes.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  response consumed on the edge where rsp_valid and rsp_ready are both high.
REQ-016 rsp_write  output  1  echo of the command's cmd_write.
REQ-017 rsp_error  output  1  1 = transaction aborted by timeout.
REQ-018 rsp_readdata  output  DATAWIDTH  read data; 0 for writes and on error.
REQ-019 avm_address  output  ADDRESSWIDTH;  avm_read  output  1;  avm_write  output  1.
REQ-020 avm_writedata  output  DATAWIDTH;  avm_byteenable  output  DATAWIDTH/8.
REQ-021 avm_readdata  input  DATAWIDTH;  avm_waitrequest  input  1 (tie to 0 for slaves without stall).

Function
REQ-022 The block SHALL implement FSM states IDLE, REQ, WAIT_RD and RESP, and SHALL hold at most one command in flight.
REQ-023 cmd_ready SHALL be 1 only in IDLE; on acceptance, all cmd_* fields SHALL be latched and the FSM SHALL move to REQ.
REQ-024 In REQ, avm_read or avm_write (per the latched op, never both) SHALL be high, driving the latched address, writedata and byteenable; all avm_* outputs SHALL be registered.
REQ-025 REQ with avm_waitrequest=0: a write SHALL go to RESP; a read SHALL go to WAIT_RD; avm_read/avm_write SHALL drop on the following cycle.
REQ-026 REQ with avm_waitrequest=1: the request and all its fields SHALL be held unchanged, and the stall counter SHALL increment.
REQ-027 With TIMEOUT>0 and the stall counter reaching TIMEOUT, the request SHALL be dropped and the FSM SHALL go to RESP with rsp_error=1 and rsp_readdata=0.
REQ-028 WAIT_RD SHALL last exactly READ_LATENCY cycles; avm_readdata SHALL be captured into rsp_readdata on the final WAIT_RD edge, then the FSM SHALL go to RESP.
REQ-029 In RESP, rsp_valid=1 and all rsp_* outputs SHALL stay stable until rsp_ready=1; on handshake the FSM SHALL go to IDLE.
REQ-030 A new command SHALL be accepted only after the response handshake; the minimum write turnaround is 3 cycles from acceptance to the next cmd_ready.
REQ-031 The stall counter SHALL be sized by $clog2(TIMEOUT+1), SHALL saturate, and SHALL clear on every entry to REQ.

Reset
REQ-032 On rst, the FSM SHALL enter IDLE and every output SHALL be 0, except cmd_ready, which SHALL be 1 from the first cycle after rst deasserts.
REQ-033 A rst asserted mid-transaction SHALL abandon the transaction: avm_read/avm_write SHALL be low on the next cycle, and no response SHALL be emitted.

Structure
REQ-034 Package avmm_master_pkg SHALL hold the state enum state_t and the packed struct cmd_t (write, address, writedata, byteenable), parameterised via the module's widths.
REQ-035 There SHALL be no sub-module; the FSM, latency counter and stall counter SHALL live in avmm_cmd_master.

Verification
REQ-036 Write addr 5, data 0xDEADBEEF, be 0xF, waitrequest=0 -> avm_write high exactly 1 cycle with address 5; rsp_valid with rsp_write=1, rsp_error=0, rsp_readdata=0.
REQ-037 Write followed by read of addr 5 against the register-memory slave model (READ_LATENCY=1) -> rsp_readdata=0xDEADBEEF, rsp_write=0, rsp_valid 2 cycles after avm_read asserts.
REQ-038 waitrequest held high 3 cycles during a write -> avm_write high 4 cycles with address/data stable; exactly one response, rsp_error=0.
REQ-039 TIMEOUT=16, waitrequest stuck high on a read -> request dropped after 16 stall cycles; rsp_error=1, rsp_readdata=0; next command accepted normally.
REQ-040 rsp_ready held low 5 cycles -> rsp_* stable throughout and cmd_ready=0; handshake on cycle 6, cmd_ready=1 on the next cycle.
REQ-041 rst pulsed during WAIT_RD -> no rsp_valid, avm_read/avm_write=0, cmd_ready=1 after reset; a subsequent read completes correctly.
